// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the ultrasonic ranging peripheral.
// Holds the FSM state enum, register map, STATUS bit positions and cm divisor.
package sonar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_ECHO,
      MEASURE,
      DONE
   } state_e;

   localparam logic [3:0] A_CTRL    = 4'h0;
   localparam logic [3:0] A_STATUS  = 4'h2;
   localparam logic [3:0] A_DIST    = 4'h4;
   localparam logic [3:0] A_ECHO    = 4'h6;
   localparam logic [3:0] A_PERIOD  = 4'h8;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_TMO  = 2;

   localparam int CM_DIV = 58;

endpackage

// File: rtl/sonar_if.sv
// sonar_if: J1 I/O bus slice seen by the sonar peripheral.
// Ports: d_in, cs, addr, rd, wr (CPU to peripheral), d_out (registered read data).
interface sonar_if;

   logic [15:0] d_in;
   logic        cs;
   logic [3:0]  addr;
   logic        rd;
   logic        wr;
   logic [15:0] d_out;

   modport master (
      output d_in, cs, addr, rd, wr,
      input  d_out
   );

   modport slave (
      input  d_in, cs, addr, rd, wr,
      output d_out
   );

endinterface

// File: rtl/sonar_us_tick.sv
// sonar_us_tick: prescaler emitting a one-cycle pulse every DIV enabled cycles.
// Ports: clk, rst (async, active low), en (count enable), clr (restart), tick.
module sonar_us_tick #(
   parameter int DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/peripheral_sonar.sv
// peripheral_sonar: HC-SR04 style ranging peripheral on the J1 I/O bus.
// Ports: clk, rst (async low), bus (sonar_if.slave), trig, echo. Macro SONAR_AUTO_EN adds PERIOD_MS.
module peripheral_sonar
   import sonar_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000
) (
   input  logic    clk,
   input  logic    rst,
   sonar_if.slave  bus,
   output logic    trig,
   input  logic    echo
);

   localparam int PRE = CLK_HZ / 1_000_000;
   localparam logic [15:0] TRIG_LAST = 16'(TRIG_US - 1);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_US - 1);
   localparam logic [5:0]  SUB_LAST  = 6'(CM_DIV - 1);

   state_e      state_q, state_d;
   logic        us_tick, echo_s, start, start_go;
   logic        tmo_hit, tmo_set, wr_en, rd_en, rd_dist;
   logic        auto_start;
   logic [1:0]  sync_q;
   logic [15:0] tmr, us_cnt, cm_cnt;
   logic [15:0] dist_q, echo_us_q, rdata, d_out_q;
   logic [5:0]  sub;
   logic        done_q, tmo_q;

   assign wr_en   = bus.cs & bus.wr;
   assign rd_en   = bus.cs & bus.rd;
   assign rd_dist = rd_en && (bus.addr == A_DIST);

   sonar_us_tick #(.DIV(PRE)) u_us (
      .clk  (clk),
      .rst  (rst),
      .en   (1'b1),
      .clr  (1'b0),
      .tick (us_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= {sync_q[0], echo};
   end

   assign echo_s = sync_q[1];

`ifdef SONAR_AUTO_EN
   logic [15:0] period, ms_cnt;
   logic        ms_tick;

   // ms prescaler restarts with every START so the period is exact
   sonar_us_tick #(.DIV(1000)) u_ms (
      .clk  (clk),
      .rst  (rst),
      .en   (us_tick),
      .clr  (start_go),
      .tick (ms_tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period <= '0;
         ms_cnt <= '0;
      end else begin
         if (wr_en && bus.addr == A_PERIOD) period <= bus.d_in;
         if (start_go) ms_cnt <= '0;
         else if (ms_tick && ms_cnt != 16'hFFFF) ms_cnt <= ms_cnt + 1'b1;
      end
   end

   assign auto_start = (period != 16'd0) && (ms_cnt >= period);
`else
   logic unused_d_in;
   assign unused_d_in = ^bus.d_in[15:1];
   assign auto_start  = 1'b0;
`endif

   assign start    = (wr_en && bus.addr == A_CTRL && bus.d_in[0]) || auto_start;
   assign start_go = (state_q == IDLE) && start;
   assign tmo_hit  = us_tick && (tmr == TMO_LAST);

   always_comb begin
      state_d = state_q;
      tmo_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_go) state_d = TRIG;
         end
         TRIG: begin
            if (us_tick && tmr == TRIG_LAST) state_d = WAIT_ECHO;
         end
         WAIT_ECHO: begin
            if (echo_s) begin
               state_d = MEASURE;
            end else if (tmo_hit) begin
               state_d = DONE;
               tmo_set = 1'b1;
            end
         end
         MEASURE: begin
            if (!echo_s) begin
               state_d = DONE;
            end else if (tmo_hit) begin
               state_d = DONE;
               tmo_set = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   assign trig = (state_q == TRIG);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr       <= '0;
         us_cnt    <= '0;
         cm_cnt    <= '0;
         sub       <= '0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
         dist_q    <= '0;
         echo_us_q <= '0;
      end else begin
         // per-state µs timer restarts on every state change
         if (state_d != state_q) tmr <= '0;
         else if (us_tick)       tmr <= tmr + 1'b1;

         if (start_go) begin
            us_cnt <= '0;
            cm_cnt <= '0;
            sub    <= '0;
         end else if (state_q == MEASURE && us_tick) begin
            if (us_cnt != 16'hFFFF) us_cnt <= us_cnt + 1'b1;
            if (sub == SUB_LAST) begin
               sub    <= '0;
               cm_cnt <= cm_cnt + 1'b1;
            end else begin
               sub <= sub + 1'b1;
            end
         end

         if (tmo_set)       tmo_q <= 1'b1;
         else if (start_go) tmo_q <= 1'b0;

         // done set has priority over the DIST_CM read clear
         if (state_q == DONE)          done_q <= 1'b1;
         else if (start_go || rd_dist) done_q <= 1'b0;

         if (state_q == DONE) begin
            dist_q    <= tmo_q ? 16'hFFFF : cm_cnt;
            echo_us_q <= tmo_q ? 16'hFFFF : us_cnt;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.addr)
         A_STATUS: begin
            rdata[ST_BUSY] = (state_q != IDLE);
            rdata[ST_DONE] = done_q;
            rdata[ST_TMO]  = tmo_q;
         end
         A_DIST:   rdata = dist_q;
         A_ECHO:   rdata = echo_us_q;
`ifdef SONAR_AUTO_EN
         A_PERIOD: rdata = period;
`endif
         default:  rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       d_out_q <= '0;
      else if (rd_en) d_out_q <= rdata;
   end

   assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_sonar.sv
// tb_peripheral_sonar: directed self-checking bench for peripheral_sonar.
// Runs at 4 MHz (4 clocks per µs) with a 2000 µs timeout to stay short.
module tb_peripheral_sonar;
   import sonar_pkg::*;

   localparam int CLK_HZ = 4_000_000;
   localparam int UC     = 4;
   localparam int TUS    = 10;
   localparam int TMO    = 2000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic echo = 1'b0;
   logic trig;

   int checks = 0;
   int errors = 0;
   int w, rises, n, ef;
   int rt[3];
   logic pt;
   logic [15:0] v;

   sonar_if bus ();

   peripheral_sonar #(
      .CLK_HZ     (CLK_HZ),
      .TRIG_US    (TUS),
      .TIMEOUT_US (TMO)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .trig (trig),
      .echo (echo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.wr = 1'b0; bus.d_in = '0;
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rd = 1'b0;
      d = bus.d_out;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a,
                         input logic [15:0] exp);
      logic [15:0] r;
      bus_rd(a, r);
      chk(tag, r, exp);
   endtask

   task automatic wait_trig_low();
      int i = 0;
      while (trig && i < 200) begin
         @(posedge clk); #1;
         i++;
      end
      if (trig) chk("trig_fall", 16'(trig), 16'd0);
   endtask

   task automatic pulse_echo(input int us);
      @(negedge clk);
      echo = 1'b1;
      repeat (us * UC) @(negedge clk);
      echo = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
      bus.addr = '0; bus.d_in = '0;

      // reset state
      repeat (3) @(posedge clk); #1;
      chk("rst_trig", 16'(trig), 16'd0);
      chk("rst_dout", bus.d_out, 16'd0);
      @(negedge clk); rst = 1'b1;
      rd_chk("rst_status", A_STATUS, 16'h0000);

      // START: trig rises on the write edge, width 9..10 µs
      bus_wr(A_CTRL, 16'h0001);
      chk("trig_rise", 16'(trig), 16'd1);
      w = 1;
      while (trig && w < 200) begin
         @(posedge clk); #1;
         if (trig) w++;
      end
      chk("trig_width", 16'(w >= 9 * UC && w <= TUS * UC), 16'd1);
      rd_chk("busy_status", A_STATUS, 16'h0001);

      // 580 µs echo -> 10 cm
      repeat (20) @(negedge clk);
      pulse_echo(580);
      rd_chk("done_status", A_STATUS, 16'h0002);
      bus_rd(A_ECHO, v);
      chk("echo_580", 16'(v >= 579 && v <= 581), 16'd1);
      rd_chk("unmapped", 4'hA, 16'h0000);
      rd_chk("dist_10", A_DIST, 16'd10);
      rd_chk("done_clr", A_STATUS, 16'h0000);

      // no echo -> timeout
      bus_wr(A_CTRL, 16'h0001);
      wait_trig_low();
      repeat (TMO * UC + 100) @(negedge clk);
      rd_chk("tmo_status", A_STATUS, 16'h0006);
      rd_chk("tmo_dist", A_DIST, 16'hFFFF);
      rd_chk("tmo_echo", A_ECHO, 16'hFFFF);

      // START during MEASURE is ignored; 1160 µs -> 20 cm
      bus_wr(A_CTRL, 16'h0001);
      wait_trig_low();
      repeat (20) @(negedge clk);
      echo = 1'b1;
      rises = 0;
      for (int i = 0; i < 1160 * UC; i++) begin
         @(negedge clk);
         if (i == 2000) begin
            bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = A_CTRL; bus.d_in = 16'h1;
         end else begin
            bus.cs = 1'b0; bus.wr = 1'b0; bus.d_in = '0;
         end
         if (trig) rises++;
      end
      echo = 1'b0;
      repeat (10) @(negedge clk);
      chk("no_retrig", 16'(rises), 16'd0);
      rd_chk("st_1160", A_STATUS, 16'h0002);
      bus_rd(A_ECHO, v);
      chk("echo_1160", 16'(v >= 1159 && v <= 1161), 16'd1);
      rd_chk("dist_20", A_DIST, 16'd20);

      // reset during TRIG drops trig at once
      bus_wr(A_CTRL, 16'h0001);
      chk("trig_rise2", 16'(trig), 16'd1);
      #2 rst = 1'b0;
      #1 chk("rst_trig_now", 16'(trig), 16'd0);
      @(negedge clk); rst = 1'b1;

      // reset mid-MEASURE clears d_out at once
      bus_wr(A_CTRL, 16'h0001);
      wait_trig_low();
      repeat (10) @(negedge clk);
      echo = 1'b1;
      repeat (400) @(negedge clk);
      rd_chk("meas_busy", A_STATUS, 16'h0001);
      #2 rst = 1'b0;
      #1;
      chk("rst_dout_now", bus.d_out, 16'd0);
      chk("rst_trig_meas", 16'(trig), 16'd0);
      echo = 1'b0;
      @(negedge clk); rst = 1'b1;
      rd_chk("post_rst_st", A_STATUS, 16'h0000);
      rd_chk("post_rst_dist", A_DIST, 16'h0000);
      bus_wr(A_CTRL, 16'h0001);
      wait_trig_low();
      repeat (20) @(negedge clk);
      pulse_echo(580);
      rd_chk("post_rst_580", A_DIST, 16'd10);

`ifdef SONAR_AUTO_EN
      // periodic auto trigger every 2 ms, sensor answers each pulse
      bus_wr(A_PERIOD, 16'd2);
      rd_chk("period_rd", A_PERIOD, 16'd2);
      n = 0; ef = -1; pt = 1'b0;
      for (int c = 0; c < 30000 && n < 3; c++) begin
         @(negedge clk);
         if (trig && !pt) begin
            rt[n] = c;
            n++;
         end
         if (!trig && pt) ef = c;
         pt = trig;
         echo = (ef >= 0) && (c >= ef + 8) && (c < ef + 48);
      end
      echo = 1'b0;
      chk("auto_count", 16'(n), 16'd3);
      if (n == 3) begin
         chk("auto_int1", 16'(rt[1] - rt[0] >= 2000 * UC - 4 &&
                              rt[1] - rt[0] <= 2000 * UC + 4), 16'd1);
         chk("auto_int2", 16'(rt[2] - rt[1] >= 2000 * UC - 4 &&
                              rt[2] - rt[1] <= 2000 * UC + 4), 16'd1);
      end
      repeat (100) @(negedge clk);
      bus_wr(A_PERIOD, 16'd0);
      rises = 0; pt = trig;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (trig && !pt) rises++;
         pt = trig;
      end
      chk("auto_off", 16'(rises), 16'd0);
`else
      bus_wr(A_PERIOD, 16'd5);
      rd_chk("period_absent", A_PERIOD, 16'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
